fixed_dot_acc: RTL and testbench

FIXED_DOT_ACC -- requirements
Module: fixed_dot_acc

---
 rtl/fixed_dot_acc_pkg.sv | 27 ++
 rtl/fixed_dot_acc_sat_add.sv | 45 ++++
 rtl/fixed_dot_acc.sv | 195 +++++++++++++++++++
 tb/tb_fixed_dot_acc.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fixed_dot_acc_pkg.sv
// ----------------------------------------------------------------------------
// fixed_dot_acc_pkg
// Shared definitions for the fixed-point dot-product accumulator:
//   - default operand width, fractional bits and element-count width
//   - Q16.16 saturation limits
//   - 3-bit controller state encoding
// ----------------------------------------------------------------------------
package fixed_dot_acc_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int FRAC_DEF  = 16;
  localparam int LEN_W_DEF = 8;

  // Largest and smallest representable signed Q16.16 values.
  localparam logic [31:0] Q16_MAX = 32'h7FFF_FFFF;
  localparam logic [31:0] Q16_MIN = 32'h8000_0000;

  typedef enum logic [2:0] {
    ST_INIT      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_MUL_ISSUE = 3'd2,
    ST_MUL_WAIT  = 3'd3,
    ST_ACC       = 3'd4,
    ST_FINISH    = 3'd5
  } state_e;

endpackage

// File: rtl/fixed_dot_acc_sat_add.sv
// ----------------------------------------------------------------------------
// fixed_sat_add
// Combinational signed saturating adder.
//   a, b : WIDTH-bit signed addends
//   sum  : a + b, clamped to the most positive / most negative WIDTH-bit value
//   ovf  : 1 when the true sum did not fit and sum was clamped
// The add is done one bit wider so the carry into the extra sign bit exposes
// overflow: the two top bits of the wide sum differ exactly when it does.
// ----------------------------------------------------------------------------
module fixed_sat_add
  import fixed_dot_acc_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  logic [WIDTH:0] wide_s;

  assign wide_s = {a[WIDTH-1], a} + {b[WIDTH-1], b};

  // Clamp toward the sign of the true (wide) result on overflow.
  always_comb begin
    sum = wide_s[WIDTH-1:0];
    ovf = 1'b0;
    if (wide_s[WIDTH] != wide_s[WIDTH-1]) begin
      ovf = 1'b1;
      if (wide_s[WIDTH]) begin
        sum = SAT_MIN;
      end else begin
        sum = SAT_MAX;
      end
    end else begin
      sum = wide_s[WIDTH-1:0];
      ovf = 1'b0;
    end
  end

endmodule

// File: rtl/fixed_dot_acc.sv
// ----------------------------------------------------------------------------
// fixed_dot_acc
// Sequential signed fixed-point dot product using an external multiplier.
// For each of N element pairs: fetch (a,b), issue them to the multiplier,
// wait for the product, then add it into a saturating accumulator.
//
// Ports
//   clk, rst              : rising-edge clock, synchronous active-high reset
//   dot_ready, dot_in_len : start request and element count N (latched at start)
//   dot_valid, dot_accept : result handshake; result held until accepted
//   dot_out_0             : signed accumulated result
//   dot_sat               : sticky, set if any accumulation step saturated
//   elem_valid/elem_ready : element-pair handshake, operands elem_a/elem_b
//   mul_ready             : one-cycle start pulse to the multiplier
//   mul_a, mul_b          : registered multiplier operands
//   mul_valid/mul_accept  : product handshake, product on mul_result
// ----------------------------------------------------------------------------
module fixed_dot_acc
  import fixed_dot_acc_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int FRAC  = FRAC_DEF,
  parameter int LEN_W = LEN_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             dot_ready,
  input  logic [LEN_W-1:0] dot_in_len,
  output logic             dot_valid,
  input  logic             dot_accept,
  output logic [WIDTH-1:0] dot_out_0,
  output logic             dot_sat,
  input  logic             elem_valid,
  output logic             elem_ready,
  input  logic [WIDTH-1:0] elem_a,
  input  logic [WIDTH-1:0] elem_b,
  output logic             mul_ready,
  output logic [WIDTH-1:0] mul_a,
  output logic [WIDTH-1:0] mul_b,
  input  logic             mul_valid,
  output logic             mul_accept,
  input  logic [WIDTH-1:0] mul_result
);

  // FRAC only documents the Q format; scaling happens in the multiplier.
  logic [31:0] frac_unused_s;
  assign frac_unused_s = 32'(FRAC);

  state_e           state_r;
  state_e           state_s;
  logic [LEN_W-1:0] len_r;
  logic [LEN_W-1:0] count_r;
  logic [WIDTH-1:0] acc_r;
  logic [WIDTH-1:0] prod_r;
  logic [WIDTH-1:0] mul_a_r;
  logic [WIDTH-1:0] mul_b_r;
  logic             dot_valid_r;
  logic             dot_sat_r;
  logic [WIDTH-1:0] sum_s;
  logic             ovf_s;
  logic             last_s;

  fixed_sat_add #(
    .WIDTH(WIDTH)
  ) u_sat_add (
    .a  (acc_r),
    .b  (prod_r),
    .sum(sum_s),
    .ovf(ovf_s)
  );

  // Compared one bit wider so N = 2^LEN_W-1 finishes without count wrapping.
  assign last_s = ({1'b0, count_r} + (LEN_W+1)'(1)) == {1'b0, len_r};

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_INIT: begin
        if (dot_ready) begin
          if (dot_in_len == {LEN_W{1'b0}}) begin
            state_s = ST_FINISH;
          end else begin
            state_s = ST_FETCH;
          end
        end else begin
          state_s = ST_INIT;
        end
      end
      ST_FETCH: begin
        if (elem_valid) begin
          state_s = ST_MUL_ISSUE;
        end else begin
          state_s = ST_FETCH;
        end
      end
      ST_MUL_ISSUE: begin
        state_s = ST_MUL_WAIT;
      end
      ST_MUL_WAIT: begin
        if (mul_valid) begin
          state_s = ST_ACC;
        end else begin
          state_s = ST_MUL_WAIT;
        end
      end
      ST_ACC: begin
        if (last_s) begin
          state_s = ST_FINISH;
        end else begin
          state_s = ST_FETCH;
        end
      end
      ST_FINISH: begin
        if (dot_accept) begin
          state_s = ST_INIT;
        end else begin
          state_s = ST_FINISH;
        end
      end
      default: begin
        state_s = ST_INIT;
      end
    endcase
  end

  // Controller state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_INIT;
    end else begin
      state_r <= state_s;
    end
  end

  // Datapath registers: length, count, operands, product, accumulator, flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      len_r       <= {LEN_W{1'b0}};
      count_r     <= {LEN_W{1'b0}};
      acc_r       <= {WIDTH{1'b0}};
      prod_r      <= {WIDTH{1'b0}};
      mul_a_r     <= {WIDTH{1'b0}};
      mul_b_r     <= {WIDTH{1'b0}};
      dot_sat_r   <= 1'b0;
      dot_valid_r <= 1'b0;
    end else begin
      case (state_r)
        ST_INIT: begin
          if (dot_ready) begin
            len_r     <= dot_in_len;
            count_r   <= {LEN_W{1'b0}};
            acc_r     <= {WIDTH{1'b0}};
            dot_sat_r <= 1'b0;
          end
        end
        ST_FETCH: begin
          if (elem_valid) begin
            mul_a_r <= elem_a;
            mul_b_r <= elem_b;
          end
        end
        ST_MUL_WAIT: begin
          if (mul_valid) begin
            prod_r <= mul_result;
          end
        end
        ST_ACC: begin
          acc_r   <= sum_s;
          count_r <= count_r + LEN_W'(1);
          if (ovf_s) begin
            dot_sat_r <= 1'b1;
          end
        end
        default: begin
        end
      endcase
      // Registered so it rises together with the entry into FINISH.
      dot_valid_r <= (state_s == ST_FINISH);
    end
  end

  // Handshake strobes are qualified with rst so they stay low while the
  // state register is still being forced back to INIT.
  assign elem_ready = (state_r == ST_FETCH) & ~rst;
  assign mul_ready  = (state_r == ST_MUL_ISSUE) & ~rst;
  assign mul_accept = (state_r == ST_MUL_WAIT) & mul_valid & ~rst;

  assign mul_a     = mul_a_r;
  assign mul_b     = mul_b_r;
  assign dot_out_0 = acc_r;
  assign dot_sat   = dot_sat_r;
  assign dot_valid = dot_valid_r;

endmodule

// File: tb/tb_fixed_dot_acc.sv
// ----------------------------------------------------------------------------
// tb_fixed_dot_acc
// Self-checking bench: directed table of vectors, reset-in-flight sequence,
// randomized runs against an arithmetic reference, and a maximum-length run.
// A behavioural Q16.16 multiplier with configurable latency answers mul_ready.
// ----------------------------------------------------------------------------
module tb_fixed_dot_acc;

  localparam int W  = 32;
  localparam int LW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          dot_ready;
  logic [LW-1:0] dot_in_len;
  logic          dot_valid;
  logic          dot_accept;
  logic [W-1:0]  dot_out_0;
  logic          dot_sat;
  logic          elem_valid;
  logic          elem_ready;
  logic [W-1:0]  elem_a;
  logic [W-1:0]  elem_b;
  logic          mul_ready;
  logic [W-1:0]  mul_a;
  logic [W-1:0]  mul_b;
  logic          mul_valid;
  logic          mul_accept;
  logic [W-1:0]  mul_result;

  fixed_dot_acc #(.WIDTH(W), .FRAC(16), .LEN_W(LW)) dut (
    .clk(clk), .rst(rst),
    .dot_ready(dot_ready), .dot_in_len(dot_in_len),
    .dot_valid(dot_valid), .dot_accept(dot_accept),
    .dot_out_0(dot_out_0), .dot_sat(dot_sat),
    .elem_valid(elem_valid), .elem_ready(elem_ready),
    .elem_a(elem_a), .elem_b(elem_b),
    .mul_ready(mul_ready), .mul_a(mul_a), .mul_b(mul_b),
    .mul_valid(mul_valid), .mul_accept(mul_accept), .mul_result(mul_result)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int va[256];
  int vb[256];
  int mdl_delay = 1;
  bit mdl_extra = 1'b0;

  typedef struct {
    int          n;
    int          a[4];
    int          b[4];
    int          gap;
    int          dly;
    bit          extra;
    int          hold;
    logic [31:0] exp_out;
    bit          exp_sat;
  } vec_t;

  vec_t tbl[7];

  function automatic int q_mul(input int a, input int b);
    longint p;
    p = longint'(a) * longint'(b);
    return int'(p >>> 16);
  endfunction

  // Reference: running sum of Q16.16 products, clamped after every addition.
  function automatic void ref_dot(input int n, output logic [31:0] r, output bit s);
    longint acc;
    acc = 64'sd0;
    s = 1'b0;
    for (int i = 0; i < n; i++) begin
      acc = acc + longint'(q_mul(va[i], vb[i]));
      if (acc > 64'sd2147483647) begin
        acc = 64'sd2147483647;
        s = 1'b1;
      end else if (acc < -64'sd2147483648) begin
        acc = -64'sd2147483648;
        s = 1'b1;
      end
    end
    r = acc[31:0];
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Behavioural multiplier: product appears mdl_delay cycles after mul_ready,
  // optionally stays valid one cycle past accept, and is abandoned after
  // four unaccepted cycles.
  initial begin : mul_model
    bit          issue;
    bit          hs;
    bit          extra_left;
    bit          pend;
    int          dcnt;
    int          age;
    int          prod;
    logic [W-1:0] ca;
    logic [W-1:0] cb;
    mul_valid = 1'b0; mul_result = 32'h0;
    extra_left = 1'b0; pend = 1'b0; dcnt = 0; age = 0; prod = 0;
    forever begin
      @(negedge clk);
      issue = mul_ready;
      hs    = mul_valid && mul_accept;
      ca    = mul_a;
      cb    = mul_b;
      @(posedge clk); #1;
      if (hs) begin
        if (mdl_extra) extra_left = 1'b1;
        else mul_valid = 1'b0;
      end else if (mul_valid) begin
        if (extra_left) begin
          mul_valid = 1'b0;
          extra_left = 1'b0;
        end else begin
          age++;
          if (age >= 4) mul_valid = 1'b0;
        end
      end
      if (issue) begin
        pend = 1'b1;
        dcnt = mdl_delay;
        prod = q_mul(int'(ca), int'(cb));
      end
      if (pend) begin
        dcnt--;
        if (dcnt <= 0) begin
          mul_valid = 1'b1;
          mul_result = prod;
          pend = 1'b0;
          age = 0;
          extra_left = 1'b0;
        end
      end
    end
  end

  // One complete transaction using va/vb, then a hold period and accept.
  task automatic run_dot(input int n, input int gap, input int dly, input bit extra,
                         input int hold, input logic [31:0] exp_out, input bit exp_sat,
                         input string tag);
    int   cycles;
    int   idx;
    int   gcnt;
    int   mr_cnt;
    int   er_cnt;
    int   limit;
    bit   hs;
    bit   unstable;
    logic [31:0] held_out;
    mdl_delay = dly;
    mdl_extra = extra;
    dot_in_len = LW'(n);
    dot_ready = 1'b1;
    elem_valid = 1'b0;
    @(posedge clk); #1;
    dot_ready = 1'b0;
    dot_in_len = LW'($urandom);
    cycles = 1; idx = 0; gcnt = gap; mr_cnt = 0; er_cnt = 0;
    limit = 4 * n * (gap + dly + 4) + 20;
    while (!dot_valid && cycles < limit) begin
      if (idx < n && gcnt == 0) begin
        elem_valid = 1'b1;
        elem_a = va[idx];
        elem_b = vb[idx];
      end else begin
        elem_valid = 1'b0;
      end
      dot_ready = 1'($urandom);
      if (mul_ready) mr_cnt++;
      if (elem_ready) er_cnt++;
      hs = elem_valid && elem_ready;
      @(posedge clk); #1;
      cycles++;
      if (hs) begin
        idx++;
        gcnt = gap;
      end else if (gcnt > 0) begin
        gcnt--;
      end
    end
    elem_valid = 1'b0;
    dot_ready = 1'b0;
    check({tag, " dot_valid"}, 64'(dot_valid), 64'd1);
    check({tag, " dot_out_0"}, 64'(dot_out_0), 64'(exp_out));
    check({tag, " dot_sat"}, 64'(dot_sat), 64'(exp_sat));
    check({tag, " mul_ready pulses"}, 64'(mr_cnt), 64'(n));
    if (n == 0) begin
      check({tag, " len0 latency<=2"}, 64'(cycles <= 2), 64'd1);
      check({tag, " len0 elem_ready"}, 64'(er_cnt), 64'd0);
    end else if (gap == 0 && dly == 1) begin
      check({tag, " latency"}, 64'(cycles), 64'(4 * n + 1));
    end
    held_out = dot_out_0;
    unstable = 1'b0;
    for (int h = 0; h < hold; h++) begin
      dot_ready = 1'($urandom);
      @(posedge clk); #1;
      if (!dot_valid || dot_out_0 !== held_out || elem_ready || mul_ready) unstable = 1'b1;
    end
    dot_ready = 1'b0;
    if (hold > 0) check({tag, " hold stable"}, 64'(unstable), 64'd0);
    dot_accept = 1'b1;
    @(posedge clk); #1;
    dot_accept = 1'b0;
    check({tag, " dot_valid drop"}, 64'(dot_valid), 64'd0);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int          k;
    bit          acc_seen;
    int          n;
    logic [31:0] e_out;
    bit          e_sat;

    tbl[0] = '{n:3, a:'{32'h00010000, 32'h00008000, 32'hFFFF0000, 32'h0},
               b:'{32'h00020000, 32'h00008000, 32'h00010000, 32'h0},
               gap:0, dly:1, extra:1'b0, hold:10, exp_out:32'h00014000, exp_sat:1'b0};
    tbl[1] = '{n:2, a:'{32'h7FFF0000, 32'h7FFF0000, 32'h0, 32'h0},
               b:'{32'h00010000, 32'h00010000, 32'h0, 32'h0},
               gap:0, dly:1, extra:1'b0, hold:2, exp_out:32'h7FFFFFFF, exp_sat:1'b1};
    tbl[2] = '{n:1, a:'{32'h00010000, 32'h0, 32'h0, 32'h0},
               b:'{32'h00010000, 32'h0, 32'h0, 32'h0},
               gap:0, dly:1, extra:1'b0, hold:2, exp_out:32'h00010000, exp_sat:1'b0};
    tbl[3] = '{n:3, a:'{32'h00030000, 32'h00018000, 32'hFFFE0000, 32'h0},
               b:'{32'h00020000, 32'h00020000, 32'h00008000, 32'h0},
               gap:5, dly:3, extra:1'b1, hold:2, exp_out:32'h00080000, exp_sat:1'b0};
    tbl[4] = '{n:2, a:'{32'h80000000, 32'h80000000, 32'h0, 32'h0},
               b:'{32'h00010000, 32'h00010000, 32'h0, 32'h0},
               gap:1, dly:2, extra:1'b1, hold:2, exp_out:32'h80000000, exp_sat:1'b1};
    tbl[5] = '{n:3, a:'{32'h7FFF0000, 32'h7FFF0000, 32'hFFFF0000, 32'h0},
               b:'{32'h00010000, 32'h00010000, 32'h00010000, 32'h0},
               gap:0, dly:1, extra:1'b0, hold:2, exp_out:32'h7FFEFFFF, exp_sat:1'b1};
    tbl[6] = '{n:0, a:'{32'h0, 32'h0, 32'h0, 32'h0},
               b:'{32'h0, 32'h0, 32'h0, 32'h0},
               gap:0, dly:1, extra:1'b0, hold:2, exp_out:32'h0, exp_sat:1'b0};

    rst = 1'b1; dot_ready = 1'b0; dot_in_len = 8'd0; dot_accept = 1'b0;
    elem_valid = 1'b0; elem_a = 32'h0; elem_b = 32'h0;

    // Reset state.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst strobes during reset", 64'({elem_ready, mul_ready, mul_accept}), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst strobes after reset", 64'({elem_ready, mul_ready, mul_accept}), 64'd0);
    check("rst dot_valid", 64'(dot_valid), 64'd0);
    check("rst dot_out_0", 64'(dot_out_0), 64'd0);
    check("rst dot_sat", 64'(dot_sat), 64'd0);
    check("rst mul_a/mul_b", 64'({mul_a, mul_b}), 64'd0);

    // Directed vector table.
    for (int i = 0; i < 7; i++) begin
      for (int j = 0; j < 4; j++) begin
        va[j] = tbl[i].a[j];
        vb[j] = tbl[i].b[j];
      end
      run_dot(tbl[i].n, tbl[i].gap, tbl[i].dly, tbl[i].extra, tbl[i].hold,
              tbl[i].exp_out, tbl[i].exp_sat, $sformatf("vec%0d", i));
    end

    // Reset while waiting on the multiplier; the late product must be ignored.
    mdl_delay = 8; mdl_extra = 1'b0;
    dot_in_len = 8'd2; dot_ready = 1'b1;
    @(posedge clk); #1;
    dot_ready = 1'b0;
    elem_valid = 1'b1; elem_a = 32'h00020000; elem_b = 32'h00020000;
    k = 0;
    while (!mul_ready && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    elem_valid = 1'b0;
    check("rstwait issue seen", 64'(mul_ready), 64'd1);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check("rstwait strobes in reset", 64'({elem_ready, mul_ready, mul_accept}), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rstwait strobes after", 64'({elem_ready, mul_ready, mul_accept}), 64'd0);
    check("rstwait outputs cleared", 64'({dot_valid, dot_sat, dot_out_0}), 64'd0);
    check("rstwait mul operands", 64'({mul_a, mul_b}), 64'd0);
    acc_seen = 1'b0;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      if (mul_accept) acc_seen = 1'b1;
    end
    check("rstwait stale product unaccepted", 64'(acc_seen), 64'd0);
    @(posedge clk); #1;
    va[0] = 32'h00030000; vb[0] = 32'h00010000;
    run_dot(1, 0, 1, 1'b0, 0, 32'h00030000, 1'b0, "post-rst");

    // Randomized runs against the reference.
    for (int r = 0; r < 20; r++) begin
      n = int'($urandom_range(32'd1, 32'd6));
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(32'd0, 32'd3) == 32'd0) va[i] = int'($urandom);
        else va[i] = int'($urandom_range(32'd0, 32'h001FFFFF)) - 32'sh00100000;
        if ($urandom_range(32'd0, 32'd3) == 32'd0) vb[i] = int'($urandom);
        else vb[i] = int'($urandom_range(32'd0, 32'h001FFFFF)) - 32'sh00100000;
      end
      ref_dot(n, e_out, e_sat);
      run_dot(n, int'($urandom_range(32'd0, 32'd3)), int'($urandom_range(32'd1, 32'd4)),
              1'($urandom), 1, e_out, e_sat, $sformatf("rand%0d", r));
    end

    // Maximum element count, back-to-back elements.
    for (int i = 0; i < 255; i++) begin
      va[i] = 32'h00010000;
      vb[i] = int'($urandom_range(32'd0, 32'h001FFFFF)) - 32'sh00100000;
    end
    ref_dot(255, e_out, e_sat);
    run_dot(255, 0, 1, 1'b0, 1, e_out, e_sat, "len255");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
